// File: rtl/reverse_double_dabble_generic.sv
// Sequential BCD-to-binary converter (reverse double dabble: shift right, then subtract 3 from nibbles >= 8).
// Optional invalid-digit flag enabled by defining REVERSE_DOUBLE_DABBLE_DIGIT_CHECK_EN.
module reverse_double_dabble_generic #(
  parameter int Output_Bit_Width = 8,
  localparam int Total_Nibbles = (Output_Bit_Width / 3) + 1
) (
  input  logic                              clk,
  input  logic                              async_rst_n,
  input  logic                              clk_en,
  input  logic [Total_Nibbles-1:0][3:0]     nibbles_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [Output_Bit_Width-1:0]       bin_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              overflow,
  output logic                              err_digit
);

  localparam int BcdW  = 4 * Total_Nibbles;
  localparam int WorkW = BcdW + Output_Bit_Width;
  localparam int CntW  = $clog2(Output_Bit_Width + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(Output_Bit_Width - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [WorkW-1:0]            work_q, work_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [Output_Bit_Width-1:0] bin_out_q, bin_out_d;
  logic                        overflow_q, overflow_d;
  logic [WorkW-1:0]            shifted, corrected;
  logic                        accept, finish;

  // Nibble >= 8 is exactly "bit 3 set"; the 4-bit subtract never borrows into a neighbour.
  function automatic logic [BcdW-1:0] correct_nibbles(input logic [BcdW-1:0] bcd);
    logic [BcdW-1:0] res;
    res = bcd;
    for (int i = 0; i < Total_Nibbles; i++) begin
      if (bcd[4*i+3]) res[4*i +: 4] = bcd[4*i +: 4] - 4'd3;
    end
    return res;
  endfunction

  assign shifted   = {1'b0, work_q[WorkW-1:1]};
  assign corrected = {correct_nibbles(shifted[WorkW-1:Output_Bit_Width]),
                      shifted[Output_Bit_Width-1:0]};
  assign accept    = clk_en && in_valid && (state_q == IDLE);
  assign finish    = clk_en && (state_q == CONVERT) && (cnt_q == LastIter);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bin_out_d  = bin_out_q;
    overflow_d = overflow_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d  = {nibbles_in, {Output_Bit_Width{1'b0}}};
            cnt_d   = '0;
            state_d = CONVERT;
          end
        end
        CONVERT: begin
          work_d = corrected;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_d    = DONE;
            bin_out_d  = corrected[Output_Bit_Width-1:0];
            overflow_d = |corrected[WorkW-1:Output_Bit_Width];
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      bin_out_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bin_out_q  <= bin_out_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef REVERSE_DOUBLE_DABBLE_DIGIT_CHECK_EN
  logic err_pending_q, err_pending_d;
  logic err_digit_q, err_digit_d;

  function automatic logic any_bad_digit(input logic [Total_Nibbles-1:0][3:0] n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < Total_Nibbles; i++) begin
      if (n[i] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Flag captured at load, surfaced only when the result is published.
  always_comb begin
    err_pending_d = err_pending_q;
    err_digit_d   = err_digit_q;
    if (accept) err_pending_d = any_bad_digit(nibbles_in);
    if (finish) err_digit_d   = err_pending_q;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      err_pending_q <= 1'b0;
      err_digit_q   <= 1'b0;
    end else begin
      err_pending_q <= err_pending_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign err_digit = err_digit_q;
`else
  assign err_digit = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_reverse_double_dabble_generic.sv
// Directed self-checking bench for reverse_double_dabble_generic at Output_Bit_Width=8.
module tb_reverse_double_dabble_generic;

  logic            clk = 1'b0;
  logic            async_rst_n = 1'b0;
  logic            clk_en = 1'b0;
  logic [2:0][3:0] nibbles_in = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      bin_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            overflow;
  logic            err_digit;

  int chk_cnt = 0;
  int pass_cnt = 0;

`ifdef REVERSE_DOUBLE_DABBLE_DIGIT_CHECK_EN
  localparam logic ErrExpBad = 1'b1;
`else
  localparam logic ErrExpBad = 1'b0;
`endif

  reverse_double_dabble_generic #(.Output_Bit_Width(8)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .nibbles_in  (nibbles_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bin_out     (bin_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  // Launch one conversion with clk_en=1; returns at the first negedge where out_valid is seen
  // (or after a 50-edge bound), with the number of edges counted from the accept edge.
  task automatic do_convert(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                            output int edges);
    @(negedge clk);
    nibbles_in = {d2, d1, d0};
    in_valid   = 1'b1;
    clk_en     = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    async_rst_n = 1'b0;
    #12;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 8'h00 ||
        overflow !== 1'b0 || err_digit !== 1'b0)
      $display("FAIL reset_state: rdy=%b vld=%b bin=%h ov=%b err=%b required rdy=1 vld=0 bin=00 ov=0 err=0",
               in_ready, out_valid, bin_out, overflow, err_digit);
    else pass_cnt++;
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  task automatic test_max_value();
    int edges;
    out_ready = 1'b1;
    do_convert(4'd2, 4'd5, 4'd5, edges);
    chk_cnt++;
    if (edges !== 9) $display("FAIL max_latency: %0d edges required 9", edges);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b1 || bin_out !== 8'hFF || overflow !== 1'b0 || err_digit !== 1'b0)
      $display("FAIL max_result: vld=%b bin=%h ov=%b err=%b required vld=1 bin=ff ov=0 err=0",
               out_valid, bin_out, overflow, err_digit);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL max_return_idle: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [3:0] d2 [4] = '{4'd0, 4'd1, 4'd2, 4'd9};
    logic [3:0] d1 [4] = '{4'd0, 4'd2, 4'd5, 4'd9};
    logic [3:0] d0 [4] = '{4'd0, 4'd8, 4'd6, 4'd9};
    logic [7:0] eb [4] = '{8'h00, 8'h80, 8'h00, 8'hE7};
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int edges;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_convert(d2[i], d1[i], d0[i], edges);
      chk_cnt++;
      if (edges !== 9 || bin_out !== eb[i] || overflow !== eo[i] || err_digit !== 1'b0)
        $display("FAIL boundary_%0d: edges=%0d bin=%h ov=%b err=%b required edges=9 bin=%h ov=%b err=0",
                 i, edges, bin_out, overflow, err_digit, eb[i], eo[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_invalid_digit();
    int edges;
    out_ready = 1'b1;
    // Raw 0x01A runs through the algorithm to 20 in either build.
    do_convert(4'd0, 4'd1, 4'd10, edges);
    chk_cnt++;
    if (edges !== 9 || bin_out !== 8'h14 || overflow !== 1'b0 || err_digit !== ErrExpBad)
      $display("FAIL invalid_digit: edges=%0d bin=%h ov=%b err=%b required edges=9 bin=14 ov=0 err=%b",
               edges, bin_out, overflow, err_digit, ErrExpBad);
    else pass_cnt++;
    do_convert(4'd0, 4'd0, 4'd7, edges);
    chk_cnt++;
    if (bin_out !== 8'h07 || err_digit !== 1'b0)
      $display("FAIL err_clears: bin=%h err=%b required bin=07 err=0", bin_out, err_digit);
    else pass_cnt++;
  endtask

  task automatic test_enable_stall();
    int  en_edges;
    logic en;
    logic [7:0] held;
    out_ready = 1'b1;
    @(negedge clk);
    nibbles_in = {4'd1, 4'd0, 4'd0};
    in_valid   = 1'b1;
    clk_en     = 1'b1;
    @(posedge clk);
    en_edges = 1;
    en = 1'b1;
    held = bin_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      en = ~en;
      clk_en = en;
      @(posedge clk);
      if (en) en_edges++;
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || en_edges !== 9 || en !== 1'b1)
      $display("FAIL stall_latency: vld=%b enabled_edges=%0d last_edge_en=%b required vld=1 9 1",
               out_valid, en_edges, en);
    else pass_cnt++;
    chk_cnt++;
    if (bin_out !== 8'h64 || overflow !== 1'b0)
      $display("FAIL stall_result: bin=%h ov=%b required bin=64 ov=0", bin_out, overflow);
    else pass_cnt++;
    clk_en = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || bin_out !== 8'h64 || in_ready !== 1'b0)
      $display("FAIL stall_hold_done: vld=%b bin=%h rdy=%b required vld=1 bin=64 rdy=0",
               out_valid, bin_out, in_ready);
    else pass_cnt++;
    clk_en = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    if (held === 8'hxx) $display("note: bin_out unknown before stall");
  endtask

  task automatic test_backpressure();
    int edges;
    out_ready = 1'b0;
    do_convert(4'd0, 4'd3, 4'd7, edges);
    chk_cnt++;
    if (edges !== 9 || bin_out !== 8'h25)
      $display("FAIL bp_result: edges=%0d bin=%h required edges=9 bin=25", edges, bin_out);
    else pass_cnt++;
    // A new request offered while DONE must be ignored.
    nibbles_in = {4'd0, 4'd0, 4'd1};
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b1 || bin_out !== 8'h25 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: vld=%b bin=%h rdy=%b required vld=1 bin=25 rdy=0",
                 i, out_valid, bin_out, in_ready);
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 8'h25)
      $display("FAIL bp_release: vld=%b rdy=%b bin=%h required vld=0 rdy=1 bin=25",
               out_valid, in_ready, bin_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int edges;
    out_ready = 1'b1;
    @(negedge clk);
    nibbles_in = {4'd1, 4'd2, 4'd3};
    in_valid   = 1'b1;
    clk_en     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 async_rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 8'h00 ||
        overflow !== 1'b0 || err_digit !== 1'b0)
      $display("FAIL reset_mid: rdy=%b vld=%b bin=%h ov=%b err=%b required rdy=1 vld=0 bin=00 ov=0 err=0",
               in_ready, out_valid, bin_out, overflow, err_digit);
    else pass_cnt++;
    @(negedge clk);
    async_rst_n = 1'b1;
    do_convert(4'd0, 4'd4, 4'd2, edges);
    chk_cnt++;
    if (edges !== 9 || bin_out !== 8'h2A || overflow !== 1'b0)
      $display("FAIL after_reset: edges=%0d bin=%h ov=%b required edges=9 bin=2a ov=0",
               edges, bin_out, overflow);
    else pass_cnt++;
  endtask

  task automatic test_loopback();
    int edges;
    logic [3:0] h, t, u;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      do_convert(h, t, u, edges);
      chk_cnt++;
      if (edges !== 9 || bin_out !== 8'(v) || overflow !== 1'b0 || err_digit !== 1'b0)
        $display("FAIL loopback_%0d: edges=%0d bin=%h ov=%b err=%b required edges=9 bin=%h ov=0 err=0",
                 v, edges, bin_out, overflow, err_digit, 8'(v));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_boundaries();
    test_invalid_digit();
    test_enable_stall();
    test_backpressure();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
